// File: rtl/poly_mod_sub.sv
// Modular subtractor for ML-KEM coefficients: (op1 - op2) mod Q, combinational
// result plus a one-cycle registered copy qualified by a valid flag.
module poly_mod_sub #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_q_o,
  output logic             valid_o
);

  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] wrapped;

  // The extra MSB of diff is the borrow; adding Q modulo 2^WIDTH folds a
  // negative difference back into [0, Q-1] for in-range operands.
  always_comb begin
    diff     = {1'b0, op1_i} - {1'b0, op2_i};
    wrapped  = diff[WIDTH-1:0] + Q_W;
    result_o = diff[WIDTH] ? wrapped : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q_o <= '0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        result_q_o <= result_o;
      end
    end
  end

endmodule

// File: tb/tb_poly_mod_sub.sv
// Self-checking bench for poly_mod_sub: directed vector table, random pairs
// against a modular-arithmetic model, and registered-path sequences.
module tb_poly_mod_sub;

  localparam int W = 12;
  localparam int QM = 3329;

  logic         clk;
  logic         rst;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         valid_in;
  logic [W-1:0] result;
  logic [W-1:0] result_q;
  logic         valid_out;

  int unsigned n_pass;
  int unsigned n_total;

  poly_mod_sub #(.WIDTH(W), .Q(QM)) dut (
    .clk        (clk),
    .rst        (rst),
    .op1_i      (op1),
    .op2_i      (op2),
    .valid_i    (valid_in),
    .result_o   (result),
    .result_q_o (result_q),
    .valid_o    (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int expect_val;
  } vec_t;

  // Reference: true subtraction, wrapped by +Q when negative, then truncated to W bits.
  function automatic int model_sub(input int a, input int b);
    int d;
    d = a - b;
    if (d < 0) d = d + QM;
    return d & ((1 << W) - 1);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  vec_t vecs[10];
  int   exp_q[$];
  int   last_exp;
  int   a;
  int   b;

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{50, 20, 30};
    vecs[1] = '{20, 50, 3299};
    vecs[2] = '{100, 100, 0};
    vecs[3] = '{0, 1, 3328};
    vecs[4] = '{3328, 0, 3328};
    vecs[5] = '{0, 3328, 1};
    vecs[6] = '{1664, 1665, 3328};
    vecs[7] = '{3328, 3328, 0};
    vecs[8] = '{4095, 0, 4095};
    vecs[9] = '{0, 4095, 3330};

    rst = 1'b1;
    valid_in = 1'b0;
    op1 = '0;
    op2 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_result_q", int'(result_q), 0);
    check("reset_valid", int'(valid_out), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      op1 = W'(vecs[i].a);
      op2 = W'(vecs[i].b);
      #1;
      check($sformatf("vec%0d_%0d-%0d", i, vecs[i].a, vecs[i].b), int'(result), vecs[i].expect_val);
    end

    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a = int'($urandom_range(QM - 1, 0));
      b = int'($urandom_range(QM - 1, 0));
      op1 = W'(a);
      op2 = W'(b);
      #1;
      check($sformatf("rand%0d_%0d-%0d", i, a, b), int'(result), model_sub(a, b));
      if (a >= b) check("rand_range_hi", int'(result < W'(QM)), 1);
    end

    // Registered path: load, then hold with valid low.
    @(negedge clk);
    op1 = 20; op2 = 50; valid_in = 1'b1;
    @(posedge clk); #1;
    check("reg_load_result_q", int'(result_q), 3299);
    check("reg_load_valid", int'(valid_out), 1);
    @(negedge clk);
    op1 = 7; op2 = 3; valid_in = 1'b0;
    #1;
    check("comb_after_load", int'(result), 4);
    @(posedge clk); #1;
    check("reg_hold_result_q", int'(result_q), 3299);
    check("reg_hold_valid", int'(valid_out), 0);

    // Reset while valid is asserted discards the pending result.
    @(negedge clk);
    op1 = 10; op2 = 1000; valid_in = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_result_q", int'(result_q), 0);
    check("midreset_valid", int'(valid_out), 0);
    check("midreset_comb", int'(result), model_sub(10, 1000));
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    @(posedge clk); #1;
    check("post_reset_valid", int'(valid_out), 0);

    // Streaming: ten back-to-back valid pairs.
    last_exp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("stream_pre_valid", int'(valid_out), 0);
      a = int'($urandom_range(QM - 1, 0));
      b = int'($urandom_range(QM - 1, 0));
      op1 = W'(a);
      op2 = W'(b);
      valid_in = 1'b1;
      exp_q.push_back(model_sub(a, b));
      @(posedge clk); #1;
      last_exp = exp_q.pop_front();
      check($sformatf("stream%0d_result_q", i), int'(result_q), last_exp);
      check($sformatf("stream%0d_valid", i), int'(valid_out), 1);
    end
    @(negedge clk);
    op1 = 1; op2 = 2; valid_in = 1'b0;
    @(posedge clk); #1;
    check("stream_end_valid", int'(valid_out), 0);
    check("stream_end_hold", int'(result_q), last_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
